// File: rtl/matrix_result_serializer.sv
// ============================================================================
// matrix_result_serializer
//
// Captures the matrix-inverse engine's WORDS parallel result words in a single
// cycle on a load strobe, then streams them out one word per transfer over a
// valid/ready link. Holding the frame here lets the engine start its next
// inversion while the previous results drain to the host.
//
// Optional feature macro: SERIALIZER_CHECKSUM_EN
//   defined   -> frame is WORDS+1 transfers; the extra final word is the XOR of
//                all captured words, sent with out_index = WORDS and out_last.
//   undefined -> frame is exactly WORDS transfers; out_last on word WORDS-1.
//
// Ports:
//   clk        in   rising-edge clock (shared with the inverse engine)
//   rst_n      in   asynchronous active-low reset
//   load       in   one-cycle capture strobe; only honoured while idle
//   din        in   WORDS*WIDTH flattened results, word k = din[k*WIDTH +: WIDTH]
//   busy       out  high while a frame is held or being sent
//   out_data   out  current word
//   out_valid  out  out_data is valid
//   out_ready  in   sink accepts out_data
//   out_last   out  high with the final word of the frame
//   out_index  out  index of the current word (WORDS for the checksum word)
// ============================================================================
module matrix_result_serializer #(
    parameter int WORDS = 50,
    parameter int WIDTH = 32,
    parameter int IDXW  = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [WORDS*WIDTH-1:0] din,
    output logic                   busy,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [IDXW-1:0]        out_index
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

`ifdef SERIALIZER_CHECKSUM_EN
    // The checksum word rides one slot past the last data word.
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS);
`else
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);
`endif

    logic [0:0]       state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] frame_buf [WORDS];
    logic [WIDTH-1:0] word_sel;
    logic             sending;
    logic             capture;
    logic             xfer;
    logic             at_last;

    assign sending = (state == ST_SEND);
    assign capture = (state == ST_IDLE) && load;
    assign xfer    = sending && out_ready;
    assign at_last = (idx == LAST_IDX);

    // Frame control: IDLE waits for a load, SEND walks idx through the frame
    // one accepted transfer at a time and drops back to IDLE after the last.
    // A load seen while sending is simply not looked at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        state <= ST_SEND;
                        idx   <= '0;
                    end
                end
                ST_SEND: begin
                    if (xfer) begin
                        if (at_last) begin
                            state <= ST_IDLE;
                        end else begin
                            idx <= idx + IDXW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Frame buffer is plain data storage; it is never cleared because the FSM
    // only exposes it while a freshly captured frame is being sent.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < WORDS; k++) begin
                frame_buf[k] <= din[k*WIDTH +: WIDTH];
            end
        end
    end

`ifdef SERIALIZER_CHECKSUM_EN
    logic [WIDTH-1:0] din_xor;
    logic [WIDTH-1:0] checksum;

    // XOR of the incoming words, folded at capture time so the checksum word
    // costs no extra cycles at the end of the frame.
    always_comb begin
        din_xor = '0;
        for (int k = 0; k < WORDS; k++) begin
            din_xor = din_xor ^ din[k*WIDTH +: WIDTH];
        end
    end

    // Checksum register, loaded alongside the frame buffer.
    always_ff @(posedge clk) begin
        if (capture) begin
            checksum <= din_xor;
        end
    end

    assign word_sel = (idx == IDXW'(WORDS)) ? checksum : frame_buf[idx];
`else
    assign word_sel = frame_buf[idx];
`endif

    // Outputs are decoded purely from state/idx/buffer registers, so neither
    // out_ready nor load can reach an output combinationally. Idle outputs are
    // forced to zero so the link shows clean values between frames.
    assign busy      = sending;
    assign out_valid = sending;
    assign out_last  = sending && at_last;
    assign out_index = sending ? idx : '0;
    assign out_data  = sending ? word_sel : '0;

endmodule
